// File: rtl/sigcol_pkg.sv
// Shared types and the signature fold used by the y signature collector
// and by anything that needs to predict its signature.
package sigcol_pkg;

    localparam int SIG_W = 32;
    localparam logic [SIG_W-1:0] SIG_INIT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } sigcol_state_e;

    // Rotate left by one, then fold in the accepted word.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] word);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/sigcol_fsm.sv
// Control for the collector: IDLE -> STREAM -> DONE -> IDLE, with the
// capture/accept strobes the datapath uses to update its registers.
module sigcol_fsm
    import sigcol_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid_i,
    input  logic          word_ready_i,
    input  logic          last_i,
    output sigcol_state_e state_o,
    output logic          sample_ready_o,
    output logic          word_valid_o,
    output logic          sig_valid_o,
    output logic          busy_o,
    output logic          capture_o,
    output logic          accept_o
);

    sigcol_state_e state_q;
    sigcol_state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: a word transfers on any edge where word_valid and word_ready
    // are both high; word_valid stays up in STREAM until that happens.
    always_comb begin
        state_d        = state_q;
        sample_ready_o = 1'b0;
        word_valid_o   = 1'b0;
        sig_valid_o    = 1'b0;
        busy_o         = 1'b0;
        capture_o      = 1'b0;
        accept_o       = 1'b0;
        case (state_q)
            IDLE: begin
                sample_ready_o = 1'b1;
                if (sample_valid_i) begin
                    capture_o = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                word_valid_o = 1'b1;
                busy_o       = 1'b1;
                if (word_ready_i) begin
                    accept_o = 1'b1;
                    if (last_i) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sig_valid_o = 1'b1;
                busy_o      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/y_signature_collector.sv
// Captures one wide y sample, streams it out as WORD_W-bit words and folds
// every accepted word into a running rotate-XOR signature.
module y_signature_collector
    import sigcol_pkg::*;
#(
    parameter int                Y_WIDTH  = 1394,
    parameter int                WORD_W   = SIG_W,
    parameter logic [WORD_W-1:0] SIG_INIT = SIG_INIT_DEF,
    localparam int               NWORDS   = (Y_WIDTH + WORD_W - 1) / WORD_W,
    localparam int               IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic [Y_WIDTH-1:0] y,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [WORD_W-1:0]  word_data,
    output logic [IDX_W-1:0]   word_idx,
    output logic               word_last,
    output logic [WORD_W-1:0]  sig,
    output logic               sig_valid,
    output logic               busy
);

    localparam int              EXT_W    = NWORDS * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    sigcol_state_e     state;
    logic              capture;
    logic              accept;
    logic              is_last;

    logic [EXT_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] sig_q, sig_d;

    assign is_last = (idx_q == LAST_IDX);

    sigcol_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .sample_valid_i (sample_valid),
        .word_ready_i   (word_ready),
        .last_i         (is_last),
        .state_o        (state),
        .sample_ready_o (sample_ready),
        .word_valid_o   (word_valid),
        .sig_valid_o    (sig_valid),
        .busy_o         (busy),
        .capture_o      (capture),
        .accept_o       (accept)
    );

    always_comb begin
        word_data = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word_data = shadow_q[i*WORD_W +: WORD_W];
            end
        end
    end

    // The zero-extending cast keeps the pad bits of the top word at 0.
    always_comb begin
        shadow_d = shadow_q;
        idx_d    = idx_q;
        sig_d    = sig_q;
        if (capture) begin
            shadow_d = EXT_W'(y);
            idx_d    = '0;
            sig_d    = SIG_INIT;
        end else if (accept) begin
            sig_d = sig_step(sig_q, word_data);
            if (!is_last) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            idx_q    <= '0;
            sig_q    <= SIG_INIT;
        end else begin
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            sig_q    <= sig_d;
        end
    end

    assign word_idx  = idx_q;
    assign word_last = (state == STREAM) && is_last;
    assign sig       = sig_q;

endmodule

// File: tb/tb_y_signature_collector.sv
// Directed bench for y_signature_collector: full streams, backpressure,
// ignored capture while busy, and reset mid-stream.
module tb_y_signature_collector;
    import sigcol_pkg::*;

    localparam int Y_WIDTH = 1394;
    localparam int WORD_W  = 32;
    localparam int NWORDS  = 44;
    localparam int IDX_W   = 6;

    logic               clk;
    logic               rst;
    logic               sample_valid;
    logic               sample_ready;
    logic [Y_WIDTH-1:0] y;
    logic               word_valid;
    logic               word_ready;
    logic [WORD_W-1:0]  word_data;
    logic [IDX_W-1:0]   word_idx;
    logic               word_last;
    logic [WORD_W-1:0]  sig;
    logic               sig_valid;
    logic               busy;

    y_signature_collector dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .y            (y),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_idx     (word_idx),
        .word_last    (word_last),
        .sig          (sig),
        .sig_valid    (sig_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                        n_cmp = 0;
    int                        n_err = 0;
    logic [WORD_W-1:0]         exp_q[$];
    logic [WORD_W-1:0]         model_sig;
    logic [NWORDS*WORD_W-1:0]  pat;
    logic [Y_WIDTH-1:0]        y_pat;
    bit                        aborted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_sample_ready"}, 64'(sample_ready), 64'd1);
        check({ph, "_word_valid"},   64'(word_valid),   64'd0);
        check({ph, "_word_data"},    64'(word_data),    64'd0);
        check({ph, "_word_idx"},     64'(word_idx),     64'd0);
        check({ph, "_word_last"},    64'(word_last),    64'd0);
        check({ph, "_sig"},          64'(sig),          64'hFFFF_FFFF);
        check({ph, "_sig_valid"},    64'(sig_valid),    64'd0);
        check({ph, "_busy"},         64'(busy),         64'd0);
    endtask

    // Called at a falling edge while idle; returns at the falling edge after capture.
    task automatic start_capture(input logic [Y_WIDTH-1:0] yv);
        logic [NWORDS*WORD_W-1:0] ext;
        check("cap_sample_ready", 64'(sample_ready), 64'd1);
        sample_valid = 1'b1;
        y            = yv;
        ext          = '0;
        ext[Y_WIDTH-1:0] = yv;
        exp_q.delete();
        for (int k = 0; k < NWORDS; k++) exp_q.push_back(ext[k*WORD_W +: WORD_W]);
        model_sig = 32'hFFFF_FFFF;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic run_words(input int hold_at, input int poke_at, input int rst_at,
                             output bit ab);
        logic [WORD_W-1:0] w;
        ab = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            w = exp_q[0];
            check("word_valid",   64'(word_valid),   64'd1);
            check("word_idx",     64'(word_idx),     64'(i));
            check("word_data",    64'(word_data),    64'(w));
            check("word_last",    64'(word_last),    64'(i == NWORDS - 1));
            check("run_sig",      64'(sig),          64'(model_sig));
            check("run_busy",     64'(busy),         64'd1);
            check("run_ready",    64'(sample_ready), 64'd0);
            if (i == hold_at) begin
                word_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("hold_valid", 64'(word_valid), 64'd1);
                    check("hold_idx",   64'(word_idx),   64'(i));
                    check("hold_data",  64'(word_data),  64'(w));
                    check("hold_last",  64'(word_last),  64'd0);
                    check("hold_sig",   64'(sig),        64'(model_sig));
                end
                word_ready = 1'b1;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("midrst");
                rst = 1'b0;
                @(negedge clk);
                check("postrst_sig_valid", 64'(sig_valid),    64'd0);
                check("postrst_ready",     64'(sample_ready), 64'd1);
                check("postrst_sig",       64'(sig),          64'hFFFF_FFFF);
                exp_q.delete();
                ab = 1'b1;
                return;
            end
            if (i == poke_at) begin
                sample_valid = 1'b1;
                y            = ~y;
            end
            void'(exp_q.pop_front());
            model_sig = sig_step(model_sig, w);
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic finish_stream(input logic [WORD_W-1:0] final_exp);
        check("done_sig_valid",  64'(sig_valid),  64'd1);
        check("done_sig",        64'(sig),        64'(final_exp));
        check("done_busy",       64'(busy),       64'd1);
        check("done_word_valid", 64'(word_valid), 64'd0);
        @(negedge clk);
        check("idle_sig_valid",  64'(sig_valid),    64'd0);
        check("idle_ready",      64'(sample_ready), 64'd1);
        check("idle_sig_held",   64'(sig),          64'(final_exp));
        check("idle_busy",       64'(busy),         64'd0);
        check("idle_word_last",  64'(word_last),    64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        word_ready   = 1'b1;
        y            = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("released");

        // All-zero sample: signature never moves off the seed.
        start_capture('0);
        run_words(-1, -1, -1, aborted);
        finish_stream(32'hFFFF_FFFF);

        // Single set bit: seed loses bit 0, rotated 43 more places to bit 11.
        start_capture(1394'd1);
        run_words(-1, -1, -1, aborted);
        finish_stream(32'hFFFF_F7FF);

        // All ones: signature alternates 0/FFFFFFFF, last word leaves pad pattern.
        start_capture('1);
        run_words(-1, -1, -1, aborted);
        check("ones_model", 64'(model_sig), 64'h0003_FFFF);
        finish_stream(32'h0003_FFFF);

        // Distinct words, backpressure at idx 10, ignored capture at idx 20.
        for (int k = 0; k < NWORDS; k++) pat[k*WORD_W +: WORD_W] = 32'hC0DE_0000 | 32'(k);
        y_pat = pat[Y_WIDTH-1:0];
        start_capture(y_pat);
        run_words(10, 20, -1, aborted);
        finish_stream(model_sig);

        // Reset at idx 30, then a fresh capture starts over from idx 0 and the seed.
        start_capture(y_pat);
        run_words(-1, -1, 30, aborted);
        check("rst_aborted", 64'(aborted), 64'd1);
        start_capture(1394'd1);
        run_words(-1, -1, -1, aborted);
        finish_stream(32'hFFFF_F7FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
